// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad row scanner.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } keypad_state_t;

  function automatic logic single_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Matrix drive/sense lines and key-code valid/ack handshake of the keypad scanner.
interface keypad_if;
  import keypad_pkg::*;

  logic [3:0]            col_in;
  logic                  key_ack;
  logic [3:0]            row_out;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_held;
  logic                  key_overrun;

  modport master (
    input  col_in, key_ack,
    output row_out, key_code, key_valid, key_held, key_overrun
  );

  modport slave (
    output col_in, key_ack,
    input  row_out, key_code, key_valid, key_held, key_overrun
  );
endinterface

// File: rtl/keypad_dwell_timer.sv
// Wrapping 0..DWELL-1 counter; o_sample_c flags the last count of each enabled period.
module keypad_dwell_timer #(
  parameter int unsigned DWELL = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_sample_c
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_sample_c = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_sample_c) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: confirms one pressed key and hands its code over a valid/ack port.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_DWELLS dwell periods.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL         = 1000,
  parameter int unsigned REPEAT_DWELLS = 250
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);

  keypad_state_t         r_state, w_state_nxt;
  logic [1:0]            r_row_idx, w_row_idx_nxt;
  logic [1:0]            r_col_idx, w_col_idx_nxt;
  logic [3:0]            r_row_out;
  logic [KEY_CODE_W-1:0] r_key_code;
  logic                  r_key_valid, r_key_held, r_key_overrun;
  logic                  w_sample, w_clear, w_emit, w_rep_sample;

  keypad_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_en       (1'b1),
    .o_sample_c (w_sample)
  );

`ifdef KEYPAD_AUTOREPEAT_EN
  keypad_dwell_timer #(.DWELL(REPEAT_DWELLS)) u_repeat (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (r_state != HELD),
    .i_en       (w_sample && (r_state == HELD)),
    .o_sample_c (w_rep_sample)
  );
`else
  // Single emission per press: the repeat path folds to a constant.
  assign w_rep_sample = (REPEAT_DWELLS == 0) && 1'b0;
`endif

  // Next-state, row/column tracking and emit decision.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    w_col_idx_nxt = r_col_idx;
    w_emit        = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_sample) begin
          if (single_hot(kp.col_in)) begin
            w_col_idx_nxt = onehot_to_idx(kp.col_in);
            w_state_nxt   = CONFIRM;
          end else begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end
      end
      CONFIRM: begin
        if (w_sample) begin
          if (kp.col_in == idx_to_onehot(r_col_idx)) begin
            w_emit      = 1'b1;
            w_state_nxt = HELD;
          end else begin
            w_row_idx_nxt = r_row_idx + 2'd1;
            w_state_nxt   = SCAN;
          end
        end
      end
      HELD: begin
        if (w_sample) begin
          if (!kp.col_in[r_col_idx]) begin
            w_row_idx_nxt = r_row_idx + 2'd1;
            w_state_nxt   = SCAN;
          end else if (w_rep_sample) begin
            w_emit = 1'b1;
          end
        end
      end
      default: w_state_nxt = SCAN;
    endcase
    w_clear = (w_state_nxt != r_state) || (w_row_idx_nxt != r_row_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SCAN;
      r_row_idx <= 2'd0;
      r_col_idx <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_idx <= w_row_idx_nxt;
      r_col_idx <= w_col_idx_nxt;
    end
  end

  // Registered outputs; an emit coinciding with key_ack keeps valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_out     <= 4'b0001;
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_held    <= 1'b0;
      r_key_overrun <= 1'b0;
    end else begin
      r_row_out     <= idx_to_onehot(w_row_idx_nxt);
      r_key_held    <= (w_state_nxt == HELD);
      r_key_overrun <= w_emit && r_key_valid && !kp.key_ack;
      if (w_emit) begin
        r_key_code  <= {r_row_idx, r_col_idx};
        r_key_valid <= 1'b1;
      end else if (kp.key_ack) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign kp.row_out     = r_row_out;
  assign kp.key_code    = r_key_code;
  assign kp.key_valid   = r_key_valid;
  assign kp.key_held    = r_key_held;
  assign kp.key_overrun = r_key_overrun;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning controller for the 4x4 matricial keyboard. It drives one keyboard row at a time and samples the four column lines after they pass through the column debouncer/synchronizer. It confirms a single pressed key and presents a 4-bit key code to the downstream consumer through a valid/ack handshake. It is the stage directly downstream of the column debouncer, and its `row_out` closes the loop through the keyboard matrix.

## Interface
- `DWELL`, default 1000: clock cycles each row is driven before columns are sampled. Legal range is 4 or more, because the debouncer path has 3 cycles of latency.
- `REPEAT_DWELLS`, default 250: dwell periods between autorepeat emissions. Used only with `KEYPAD_AUTOREPEAT_EN`.
- `clk`  in  1  system clock; one clock only.
- `reset`  in  1  asynchronous, active-high reset.
- `col_in`  in  4  debounced, synchronized columns. Active-high: 1 means a key in the driven row is closed on that column.
- `key_ack`  in  1  consumer accepts the current `key_code`.
- `row_out`  out  4  one-hot, active-high row drive.
- `key_code`  out  4  `{row_idx[1:0], col_idx[1:0]}` of the confirmed key.
- `key_valid`  out  1  code pending; held until acknowledged.
- `key_held`  out  1  confirmed key is still pressed.
- `key_overrun`  out  1  one-cycle pulse when an emission finds the previous code still pending.

## Operation
- **Reset values:** `row_out`=4'b0001, `key_code`=0, `key_valid`=0, `key_held`=0, `key_overrun`=0, state SCAN, `row_idx`=0, dwell counter=0.
- **Dwell counter:** counts 0..`DWELL`-1 and is cleared on every row change and every state change. "Sample" means the cycle where the count equals `DWELL`-1.
- **SCAN state:** drive row `row_idx`. At sample:
  - `col_in`==0: advance `row_idx` (3 wraps to 0) and stay in SCAN.
  - Exactly one bit set: latch `col_idx` and go to CONFIRM; the row is not advanced.
  - Two or more bits set (ghosting or multi-press): ignore and advance the row.
- **CONFIRM state:** hold the same row for another dwell. At sample:
  - `col_in` equals the one-hot of the latched `col_idx`: emit and go to HELD.
  - Otherwise: advance the row and return to SCAN without emitting.
- **Emit:** `key_code`<={row_idx,col_idx}; `key_valid`<=1. If `key_valid` was already 1 without `key_ack` in that cycle, pulse `key_overrun` and overwrite the code.
- **HELD state:** `key_held`=1 and the row is held. At each sample, if `col_in[col_idx]`==0, clear `key_held`, advance the row and return to SCAN.
- **Handshake:**
  - `key_valid` falls the cycle after `key_ack` is sampled high while valid.
  - `key_ack` while not valid is ignored.
  - An emit in the same cycle as `key_ack` wins: valid stays 1, the code updates, and there is no overrun.
- **Reset mid-operation:** all state returns to its reset values immediately (asynchronous), including a pending `key_valid`.

## Timing
- `row_out` changes on the clock edge following the sample cycle.
- For a key that is stable while its row is driven, `key_valid` rises 2·`DWELL` cycles after the row first asserts, registered on the edge after the CONFIRM sample.
- Release is detected within one dwell plus 3 cycles of debouncer latency.
- Worst-case full-matrix scan with no key pressed is 4·`DWELL` cycles.
- All outputs are registered and there are no combinational paths from input to output.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In HELD, a dwell-period counter re-emits the same code every `REPEAT_DWELLS` samples while the key stays down, with the same overrun rule.
  - The counter clears on entering HELD.
- `KEYPAD_AUTOREPEAT_EN` undefined: exactly one emission per press, and the repeat counter is not synthesized.

## Structure
- `keypad_pkg` holds:
  - the state enum `keypad_state_t` {SCAN, CONFIRM, HELD};
  - the key code width constant `KEY_CODE_W`=4;
  - a one-hot to index function for 4 bits with a `single_hot` check.
- Sub-module `keypad_dwell_timer` holds the parameterized dwell counter with clear input and sample-pulse output, `$clog2(DWELL)` bits wide. It is reused for the repeat counter.

## Test plan
All scenarios use `DWELL`=4.
- **Idle:** `col_in`=0 after reset → `row_out` cycles 0001, 0010, 0100, 1000, 0001 every 4 cycles; `key_valid` stays 0.
- **Single press:** `col_in`=4'b0100 while `row_out`=4'b0010, held → `key_valid`=1 with `key_code`=4'h6 8 cycles after row assertion; `key_ack` pulse → `key_valid` 0 next cycle.
- **Bounce reject:** col 4'b0001 present during SCAN sample on row 0, removed before the CONFIRM sample → no emission, scan resumes at row 1.
- **Ghost reject:** `col_in`=4'b0011 on row 2 → no CONFIRM entry, row advances to 3.
- **Overrun:** two presses (codes 4'h1 then 4'hF) without `key_ack` → `key_overrun` pulses once, and `key_code`=4'hF with valid still 1.
- **Async reset:** `reset` asserted mid-HELD with valid pending → all outputs at reset values immediately, `row_out`=4'b0001.
